sram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares port 0 of the 16x32 dual-port SRAM macro between the UART command controller (requester 0) and a second on-chip master such as a fill/scrub engine (requester 1). It accepts held-until-granted access requests, drives registered chip-select, write-enable, address and write data onto the macro pins, and returns read data with a valid strobe to the owning requester. It sits between the requesters and the SRAM instance. Port 1 of the macro stays tied off.

---
 rtl/sram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between two held-until-granted requesters.
// All macro pins, grants and read-return strobes are registered; rdata passes straight through.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              busy
);

  logic              csb_n_q, csb_n_d;
  logic              we_n_q, we_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              busy_q, busy_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              elig0, elig1;
  logic              win0, win1;

  // Arbitration and next pin values; the granted requester is masked while it drops req
  always_comb begin
    elig0     = req0 & ~gnt0_q;
    elig1     = req1 & ~gnt1_q;
    win0      = elig0 & (~elig1 | ~prio_q);
    win1      = elig1 & (~elig0 | prio_q);

    csb_n_d   = 1'b1;
    we_n_d    = 1'b1;
    addr_d    = addr_q;
    din_d     = din_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    prio_d    = prio_q;
    owner_d   = owner_q;

    if (win0) begin
      csb_n_d = 1'b0;
      we_n_d  = ~we0;
      addr_d  = addr0;
      din_d   = wdata0;
      gnt0_d  = 1'b1;
      owner_d = 1'b0;
      prio_d  = 1'b1;
    end else if (win1) begin
      csb_n_d = 1'b0;
      we_n_d  = ~we1;
      addr_d  = addr1;
      din_d   = wdata1;
      gnt1_d  = 1'b1;
      owner_d = 1'b1;
      prio_d  = 1'b0;
    end

    // A read on the pins this cycle returns to its owner next cycle
    rvalid0_d = ~csb_n_q & we_n_q & ~owner_q;
    rvalid1_d = ~csb_n_q & we_n_q & owner_q;
    busy_d    = ~csb_n_d | rvalid0_d | rvalid1_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_n_q   <= 1'b1;
      we_n_q    <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= 1'b0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      csb_n_q   <= csb_n_d;
      we_n_q    <= we_n_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      busy_q    <= busy_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
    end
  end

  assign csb_n        = csb_n_q;
  assign we_n         = we_n_q;
  assign addr         = addr_q;
  assign sram_data_in = din_q;
  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign busy         = busy_q;
  assign rdata        = sram_data_out;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM macro model, requester queues and a transaction-level
// reference (shadow memory, round-robin winner rule, expected pin/strobe values per cycle).
module tb_sram_port_arbiter;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int          LIMIT  = 3000;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } op_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              csb_n, we_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out = '0;
  logic              busy;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  int checks = 0;
  int errors = 0;

  // Reference model state
  op_t               rq [2][$];
  op_t               cur [2];
  bit                pend [2];
  bit                mgnt [2];
  int                mprio;
  int                iss_owner;
  bit                exp_rv [2];
  logic [DATA_W-1:0] exp_rd;
  logic              exp_csb_n, exp_we_n, exp_busy;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_din;
  logic [DATA_W-1:0] shadow [DEPTH];
  int                go_pct;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .csb_n(csb_n), .we_n(we_n), .addr(addr),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out), .busy(busy)
  );

  // Synchronous single-port SRAM macro: dout valid the cycle after a read
  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) mem[addr] <= sram_data_in;
      else       sram_data_out <= mem[addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    op_t o;
    o.we = we; o.a = a; o.d = d;
    rq[i].push_back(o);
  endtask

  task automatic junk(input int i);
    cur[i].we = 1'($urandom);
    cur[i].a  = ADDR_W'($urandom);
    cur[i].d  = $urandom;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rq[i].delete();
      pend[i] = 1'b0; mgnt[i] = 1'b0; exp_rv[i] = 1'b0;
      junk(i);
    end
    mprio = 0; iss_owner = 0;
    exp_csb_n = 1'b1; exp_we_n = 1'b1; exp_busy = 1'b0;
    exp_addr = '0; exp_din = '0; exp_rd = '0;
  endtask

  task automatic drive();
    req0 = pend[0]; we0 = cur[0].we; addr0 = cur[0].a; wdata0 = cur[0].d;
    req1 = pend[1]; we1 = cur[1].we; addr1 = cur[1].a; wdata1 = cur[1].d;
  endtask

  task automatic check_all();
    chk("gnt0", 64'(gnt0), 64'(mgnt[0]));
    chk("gnt1", 64'(gnt1), 64'(mgnt[1]));
    chk("csb_n", 64'(csb_n), 64'(exp_csb_n));
    chk("we_n", 64'(we_n), 64'(exp_we_n));
    chk("addr", 64'(addr), 64'(exp_addr));
    chk("sram_data_in", 64'(sram_data_in), 64'(exp_din));
    chk("rvalid0", 64'(rvalid0), 64'(exp_rv[0]));
    chk("rvalid1", 64'(rvalid1), 64'(exp_rv[1]));
    chk("busy", 64'(busy), 64'(exp_busy));
    if (exp_rv[0] || exp_rv[1]) chk("rdata", 64'(rdata), 64'(exp_rd));
  endtask

  // One clock: predict the edge from the rules, update requesters, check at negedge
  task automatic step();
    int  w;
    bit  el0, el1;
    @(posedge clk);
    el0 = pend[0] && !mgnt[0];
    el1 = pend[1] && !mgnt[1];
    w = -1;
    if (el0 && el1) w = mprio;
    else if (el0)   w = 0;
    else if (el1)   w = 1;

    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    if (!exp_csb_n && exp_we_n) begin
      exp_rv[iss_owner] = 1'b1;
      exp_rd = shadow[exp_addr];
    end
    if (!exp_csb_n && !exp_we_n) shadow[exp_addr] = exp_din;

    for (int i = 0; i < 2; i++) if (mgnt[i]) begin pend[i] = 1'b0; junk(i); end

    mgnt[0] = 1'b0; mgnt[1] = 1'b0;
    if (w >= 0) begin
      mgnt[w]   = 1'b1;
      exp_csb_n = 1'b0;
      exp_we_n  = ~cur[w].we;
      exp_addr  = cur[w].a;
      exp_din   = cur[w].d;
      iss_owner = w;
      mprio     = 1 - w;
    end else begin
      exp_csb_n = 1'b1;
      exp_we_n  = 1'b1;
    end
    exp_busy = !exp_csb_n || exp_rv[0] || exp_rv[1];

    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && rq[i].size() != 0 && $urandom_range(99) < 32'(go_pct)) begin
        cur[i]  = rq[i].pop_front();
        pend[i] = 1'b1;
      end
    end
    #1;
    drive();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while ((rq[0].size() != 0 || rq[1].size() != 0 || pend[0] || pend[1] ||
            !exp_csb_n || exp_rv[0] || exp_rv[1]) && n < LIMIT) begin
      step();
      n++;
    end
    checks++;
    assert (n < LIMIT) else begin
      errors++;
      $error("FAIL %s_timeout: cycles=%0d limit=%0d", tag, n, LIMIT);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
    go_pct = 100;
    model_reset();
    reset = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Fill memory with random words from both requesters
    for (int a = 0; a < 8; a++) begin
      push(0, 1'b1, ADDR_W'(a), $urandom);
      push(1, 1'b1, ADDR_W'(a + 8), $urandom);
    end
    run_until_idle("fill");

    // Requester 0 write then read back
    push(0, 1'b1, 4'd5, 32'hDEADBEEF);
    push(0, 1'b0, 4'd5, '0);
    run_until_idle("wr_rd");
    chk("shadow5", 64'(shadow[5]), 64'(32'hDEADBEEF));

    // Reset asserted while a read is on the pins
    push(0, 1'b0, 4'd7, '0);
    n = 0;
    while (!mgnt[0] && n < 50) begin step(); n++; end
    chk("rst_setup_csb_n", 64'(csb_n), 64'(1'b0));
    #1 reset = 1'b1;
    #1;
    model_reset();
    drive();
    chk("rst_async_csb_n", 64'(csb_n), 64'(1'b1));
    chk("rst_async_we_n", 64'(we_n), 64'(1'b1));
    chk("rst_async_gnt0", 64'(gnt0), 64'(1'b0));
    chk("rst_async_gnt1", 64'(gnt1), 64'(1'b0));
    chk("rst_async_rvalid0", 64'(rvalid0), 64'(1'b0));
    chk("rst_async_rvalid1", 64'(rvalid1), 64'(1'b0));
    chk("rst_async_busy", 64'(busy), 64'(1'b0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Simultaneous requests twice: priority resets to 0, then toggles
    push(0, 1'b0, 4'd1, '0);
    push(1, 1'b0, 4'd2, '0);
    run_until_idle("contend_a");
    push(0, 1'b0, 4'd1, '0);
    push(1, 1'b0, 4'd2, '0);
    run_until_idle("contend_b");

    // Interleaved continuous reads
    for (int k = 0; k < 8; k++) begin
      push(0, 1'b0, 4'd1, '0);
      push(1, 1'b0, 4'd2, '0);
    end
    run_until_idle("interleave");

    // Single requester held high across back-to-back reads
    push(1, 1'b0, 4'd3, '0);
    push(1, 1'b0, 4'd4, '0);
    run_until_idle("hold");

    // Write by requester 1 alongside a read by requester 0, then read the written word
    push(1, 1'b1, 4'd15, 32'h12345678);
    push(0, 1'b0, 4'd0, '0);
    run_until_idle("isolate");
    push(0, 1'b0, 4'd15, '0);
    run_until_idle("isolate_rd");
    chk("shadow15", 64'(shadow[15]), 64'(32'h12345678));

    // Randomized traffic with random request gaps
    go_pct = 60;
    for (int k = 0; k < 200; k++) begin
      push(0, 1'($urandom), ADDR_W'($urandom), $urandom);
      push(1, 1'($urandom), ADDR_W'($urandom), $urandom);
    end
    run_until_idle("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
